// File: rtl/md_issue_ctrl_pkg.sv
// Shared definitions for the multiply/divide issue controller: FSM encoding and default sizing.
package md_issue_ctrl_pkg;

  localparam int unsigned MdMaxWait = 16;
  localparam int unsigned MdCntW    = 5;
  localparam int unsigned MdPerfW   = 32;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StLaunch = 2'd1,
    StWait   = 2'd2
  } md_state_e;

endpackage

// File: rtl/md_issue_ctrl_if.sv
// Pipeline/MD-unit handshake bundle seen by the issue controller.
interface md_issue_ctrl_if #(
  parameter int unsigned PERF_W = 32
);
  logic              d_md_use;
  logic              e_md_op;
  logic              e_md_move;
  logic              e_valid;
  logic              flush;
  logic              md_busy;
  logic              md_start;
  logic              md_move_we;
  logic              stall_d;
  logic              md_timeout;
  logic [PERF_W-1:0] md_stall_cnt;

  modport master (
    input  d_md_use, e_md_op, e_md_move, e_valid, flush, md_busy,
    output md_start, md_move_we, stall_d, md_timeout, md_stall_cnt
  );

  modport slave (
    output d_md_use, e_md_op, e_md_move, e_valid, flush, md_busy,
    input  md_start, md_move_we, stall_d, md_timeout, md_stall_cnt
  );
endinterface

// File: rtl/md_issue_ctrl.sv
// Issues Start to the multiply/divide unit, tracks its Busy handshake, stalls D-stage
// HI/LO users until the result lands, and flags a unit that never finishes.
module md_issue_ctrl
  import md_issue_ctrl_pkg::*;
#(
  parameter int unsigned MAX_WAIT = MdMaxWait,
  parameter int unsigned CNT_W    = MdCntW,
  parameter int unsigned PERF_W   = MdPerfW
) (
  input logic           clk,
  input logic           reset,
  md_issue_ctrl_if.master md
);

  localparam logic [CNT_W-1:0] MaxWaitCnt = CNT_W'(MAX_WAIT);

  md_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              timeout_q, timeout_d;
  logic [PERF_W-1:0] stall_cnt_q, stall_cnt_d;

  logic start, move_we, stall;

  // All combinational outputs are forced low while reset is held.
  always_comb begin
    start   = ~reset & (state_q == StIdle) & md.e_md_op & md.e_valid & ~md.flush;
    move_we = ~reset & (state_q == StIdle) & md.e_md_move & md.e_valid & ~md.flush;
    stall   = ~reset & md.d_md_use & ((state_q != StIdle) | start);
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
    unique case (state_q)
      StIdle: begin
        if (start) state_d = StLaunch;
      end
      StLaunch: begin
        // Busy must be visible the cycle after Start; otherwise the unit is dead.
        if (md.md_busy) begin
          state_d = StWait;
          cnt_d   = CNT_W'(1);
        end else begin
          state_d   = StIdle;
          timeout_d = 1'b1;
        end
      end
      StWait: begin
        if (!md.md_busy) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else if (cnt_q == MaxWaitCnt) begin
          state_d   = StIdle;
          cnt_d     = '0;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall) stall_cnt_d = stall_cnt_q + PERF_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      timeout_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      timeout_q   <= timeout_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign md.md_start     = start;
  assign md.md_move_we   = move_we;
  assign md.stall_d      = stall;
  assign md.md_timeout   = timeout_q;
  assign md.md_stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_md_issue_ctrl.sv
// Directed bench for md_issue_ctrl: issue, stall, flush, timeout and reset scenarios.
module tb_md_issue_ctrl;
  import md_issue_ctrl_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  md_issue_ctrl_if #(.PERF_W(32)) mif ();

  md_issue_ctrl #(
    .MAX_WAIT(16),
    .CNT_W   (5),
    .PERF_W  (32)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .md   (mif.master)
  );

  task automatic set_in(input logic use_i, input logic op_i, input logic mv_i,
                        input logic vld_i, input logic fl_i, input logic busy_i);
    mif.d_md_use  = use_i;
    mif.e_md_op   = op_i;
    mif.e_md_move = mv_i;
    mif.e_valid   = vld_i;
    mif.flush     = fl_i;
    mif.md_busy   = busy_i;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change at negedge; checks happen 1ns later, well away from posedge.
  task automatic nxt;
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    set_in(1, 1, 1, 1, 0, 0);
    nxt(); nxt();
    #1;
    chk("rst_start", 32'(mif.md_start), 0);
    chk("rst_move_we", 32'(mif.md_move_we), 0);
    chk("rst_stall", 32'(mif.stall_d), 0);
    chk("rst_state", 32'(dut.state_q), 32'(StIdle));
    chk("rst_timeout", 32'(mif.md_timeout), 0);
    chk("rst_stall_cnt", mif.md_stall_cnt, 0);

    // 1: mult in E, mfhi in D, Busy high for 5 cycles.
    reset = 1'b0;
    set_in(1, 1, 0, 1, 0, 0); #1;
    chk("t1_start", 32'(mif.md_start), 1);
    chk("t1_stall_c0", 32'(mif.stall_d), 1);
    nxt(); set_in(1, 0, 0, 0, 0, 1); #1;
    chk("t1_state_launch", 32'(dut.state_q), 32'(StLaunch));
    chk("t1_start_once", 32'(mif.md_start), 0);
    chk("t1_stall_c1", 32'(mif.stall_d), 1);
    nxt(); #1;
    chk("t1_state_wait", 32'(dut.state_q), 32'(StWait));
    chk("t1_cnt1", 32'(dut.cnt_q), 1);
    nxt(); nxt(); nxt(); #1;
    chk("t1_stall_c5", 32'(mif.stall_d), 1);
    nxt(); set_in(1, 0, 0, 0, 0, 0); #1;
    chk("t1_stall_c6", 32'(mif.stall_d), 1);
    nxt(); #1;
    chk("t1_state_idle", 32'(dut.state_q), 32'(StIdle));
    chk("t1_stall_released", 32'(mif.stall_d), 0);
    chk("t1_stall_cnt", mif.md_stall_cnt, 7);

    // 2: div issued, addu in D never stalls; mthi in E while WAIT not written.
    set_in(0, 1, 0, 1, 0, 0); #1;
    chk("t2_start", 32'(mif.md_start), 1);
    chk("t2_stall_c0", 32'(mif.stall_d), 0);
    nxt(); set_in(0, 0, 0, 1, 0, 1); #1;
    chk("t2_stall_c1", 32'(mif.stall_d), 0);
    nxt(); set_in(0, 0, 1, 1, 0, 1); #1;
    chk("t2_state_wait", 32'(dut.state_q), 32'(StWait));
    chk("t2_stall_wait", 32'(mif.stall_d), 0);
    chk("t2_move_blocked", 32'(mif.md_move_we), 0);
    nxt(); set_in(0, 0, 0, 0, 0, 0);
    nxt(); #1;
    chk("t2_state_idle", 32'(dut.state_q), 32'(StIdle));
    chk("t2_stall_cnt", mif.md_stall_cnt, 7);

    // 3: flush blocks Start and HI/LO move.
    set_in(1, 1, 0, 1, 1, 0); #1;
    chk("t3_start_flushed", 32'(mif.md_start), 0);
    chk("t3_stall_flushed", 32'(mif.stall_d), 0);
    nxt(); set_in(0, 0, 1, 1, 1, 0); #1;
    chk("t3_state_idle", 32'(dut.state_q), 32'(StIdle));
    chk("t3_move_flushed", 32'(mif.md_move_we), 0);
    set_in(0, 0, 1, 1, 0, 0); #1;
    chk("t3_move_we", 32'(mif.md_move_we), 1);

    // 4a: Busy never rises after Start.
    nxt(); set_in(0, 1, 0, 1, 0, 0);
    nxt(); set_in(0, 0, 0, 0, 0, 0); #1;
    chk("t4a_state_launch", 32'(dut.state_q), 32'(StLaunch));
    chk("t4a_timeout_pre", 32'(mif.md_timeout), 0);
    nxt(); #1;
    chk("t4a_timeout", 32'(mif.md_timeout), 1);
    chk("t4a_state_idle", 32'(dut.state_q), 32'(StIdle));
    reset = 1'b1;
    nxt(); #1;
    chk("t4a_timeout_cleared", 32'(mif.md_timeout), 0);
    reset = 1'b0;

    // 4b: Busy stuck high; timeout when cnt reaches 16.
    set_in(0, 1, 0, 1, 0, 0);
    nxt(); set_in(0, 0, 0, 0, 0, 1);
    nxt(); #1;
    chk("t4b_cnt1", 32'(dut.cnt_q), 1);
    for (int i = 2; i <= 16; i++) nxt();
    #1;
    chk("t4b_cnt16", 32'(dut.cnt_q), 16);
    chk("t4b_state_wait16", 32'(dut.state_q), 32'(StWait));
    chk("t4b_timeout_pre", 32'(mif.md_timeout), 0);
    nxt(); #1;
    chk("t4b_timeout", 32'(mif.md_timeout), 1);
    chk("t4b_state_idle", 32'(dut.state_q), 32'(StIdle));
    nxt(); nxt(); #1;
    chk("t4b_timeout_sticky", 32'(mif.md_timeout), 1);
    reset = 1'b1;
    set_in(0, 0, 0, 0, 0, 0);
    nxt();
    reset = 1'b0;

    // 5: reset mid-WAIT at cnt=4.
    set_in(1, 1, 0, 1, 0, 0);
    nxt(); set_in(1, 0, 0, 0, 0, 1);
    nxt(); nxt(); nxt(); nxt(); #1;
    chk("t5_cnt4", 32'(dut.cnt_q), 4);
    chk("t5_stall_cnt", mif.md_stall_cnt, 5);
    reset = 1'b1;
    set_in(1, 1, 1, 1, 0, 1); #1;
    chk("t5_stall_gated", 32'(mif.stall_d), 0);
    chk("t5_start_gated", 32'(mif.md_start), 0);
    nxt(); set_in(1, 0, 0, 0, 0, 0); #1;
    chk("t5_state_idle", 32'(dut.state_q), 32'(StIdle));
    chk("t5_cnt0", 32'(dut.cnt_q), 0);
    chk("t5_stall_cnt0", mif.md_stall_cnt, 0);
    reset = 1'b0;

    // 6: flush during WAIT does not cancel the in-flight op.
    set_in(1, 1, 0, 1, 0, 0);
    nxt(); set_in(1, 0, 0, 0, 0, 1);
    nxt(); set_in(1, 0, 0, 1, 1, 1); #1;
    chk("t6_state_wait_flush", 32'(dut.state_q), 32'(StWait));
    chk("t6_stall_flush", 32'(mif.stall_d), 1);
    nxt(); set_in(1, 0, 0, 0, 0, 1); #1;
    chk("t6_state_wait_after", 32'(dut.state_q), 32'(StWait));
    chk("t6_cnt2", 32'(dut.cnt_q), 2);
    nxt(); set_in(1, 0, 0, 0, 0, 0); #1;
    chk("t6_stall_last", 32'(mif.stall_d), 1);
    nxt(); #1;
    chk("t6_state_idle", 32'(dut.state_q), 32'(StIdle));
    chk("t6_stall_released", 32'(mif.stall_d), 0);
    chk("t6_stall_cnt", mif.md_stall_cnt, 5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
